// File: rtl/branch_history_indexer_if.sv
// ---------------------------------------------------------------------------
// branch_history_indexer_if
//
// Purpose : groups the pipeline-side signals of the global-history indexer
//           (Fetch PC, Decode/Execute pipeline control, branch resolution
//           and the index/history outputs) into one bundle.
//
// Modports:
//   master - pipeline/PHT side: drives PC, stall/flush and branch info,
//            receives the indices, mispredict flag and both histories.
//   slave  - the indexer itself: the mirror image of master.
//
// HIST_W must match the HIST_W of the indexer instance it connects to.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface branch_history_indexer_if #(
  parameter int HIST_W = 3
);
  logic [31:0]       PCF;
  logic              stallD;
  logic              flushD;
  logic              flushE;
  logic              branchD;
  logic              predTakenD;
  logic              branchE;
  logic              branchTakenE;
  logic              branchPredictedE;
  logic [HIST_W-1:0] phtIdxF;
  logic [HIST_W-1:0] PHTinpId;
  logic              mispredictE;
  logic [HIST_W-1:0] specHist;
  logic [HIST_W-1:0] commitHist;

  modport master (
    output PCF, stallD, flushD, flushE, branchD, predTakenD,
           branchE, branchTakenE, branchPredictedE,
    input  phtIdxF, PHTinpId, mispredictE, specHist, commitHist
  );

  modport slave (
    input  PCF, stallD, flushD, flushE, branchD, predTakenD,
           branchE, branchTakenE, branchPredictedE,
    output phtIdxF, PHTinpId, mispredictE, specHist, commitHist
  );
endinterface

// File: rtl/branch_history_indexer.sv
// ---------------------------------------------------------------------------
// branch_history_indexer
//
// Purpose : gshare index generator for an 8-entry pattern history table.
//           Keeps a speculative and a committed global history register,
//           forms the Fetch lookup index (PC bits XOR speculative history),
//           and carries that index through Decode to Execute so the PHT
//           update writes the same entry that produced the prediction.
//           An Execute misprediction rebuilds the speculative history from
//           the committed history plus the resolved outcome.
//
// Parameters:
//   HIST_W - history / index width (must match the PHT index width)
//   PC_LSB - lowest PC bit folded into the index
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - slave side of branch_history_indexer_if
//           in : PCF, stallD, flushD, flushE, branchD, predTakenD,
//                branchE, branchTakenE, branchPredictedE
//           out: phtIdxF, PHTinpId, mispredictE, specHist, commitHist
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module branch_history_indexer #(
  parameter int HIST_W = 3,
  parameter int PC_LSB = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  branch_history_indexer_if.slave   bus
);

  logic [HIST_W-1:0] specHist;
  logic [HIST_W-1:0] commitHist;
  logic [HIST_W-1:0] idxD;
  logic [HIST_W-1:0] idxE;
  logic              validD;
  logic              validE;

  logic [HIST_W-1:0] phtIdxF;
  logic              mispredictE;
  logic              commitEn;
  logic              specEn;

  // PC bits outside the index window do not take part in the hash.
  logic              unusedPcBits;
  assign unusedPcBits = ^{bus.PCF[31:PC_LSB+HIST_W], bus.PCF[PC_LSB-1:0]};

  // Fetch lookup index: purely combinational so the PHT read happens in the
  // same cycle as the PC.
  assign phtIdxF = bus.PCF[PC_LSB +: HIST_W] ^ specHist;

  // Only a live (non-bubble) branch in Execute may resolve or commit.
  assign commitEn    = validE & bus.branchE;
  assign mispredictE = commitEn & (bus.branchTakenE ^ bus.branchPredictedE);

  // A Decode branch shifts its prediction into the speculative history only
  // when it actually advances into Execute this edge.
  assign specEn = validD & bus.branchD & ~bus.stallD & ~bus.flushE;

  // NOTE: non-blocking assignments throughout, so recovery below reads the
  // commitHist value from before this edge, exactly as the committed state
  // stood when the mispredicted branch was fetched-and-resolved.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      specHist   <= '0;
      commitHist <= '0;
      idxD       <= '0;
      idxE       <= '0;
      validD     <= 1'b0;
      validE     <= 1'b0;
    end else begin
      // Decode register: stall holds and outranks flush.
      if (!bus.stallD) begin
        if (bus.flushD) begin
          idxD   <= '0;
          validD <= 1'b0;
        end else begin
          idxD   <= phtIdxF;
          validD <= 1'b1;
        end
      end

      // Execute register: a held Decode stage feeds a bubble forward.
      if (bus.flushE || bus.stallD) begin
        idxE   <= '0;
        validE <= 1'b0;
      end else begin
        idxE   <= idxD;
        validE <= validD;
      end

      if (commitEn) begin
        commitHist <= {commitHist[HIST_W-2:0], bus.branchTakenE};
      end

      // Recovery outranks any speculative shift from Decode in the same cycle.
      if (mispredictE) begin
        specHist <= {commitHist[HIST_W-2:0], bus.branchTakenE};
      end else if (specEn) begin
        specHist <= {specHist[HIST_W-2:0], bus.predTakenD};
      end
    end
  end

  assign bus.phtIdxF     = phtIdxF;
  assign bus.PHTinpId    = idxE;
  assign bus.mispredictE = mispredictE;
  assign bus.specHist    = specHist;
  assign bus.commitHist  = commitHist;

endmodule

// File: tb/tb_branch_history_indexer.sv
`timescale 1ns/1ps

module tb_branch_history_indexer;

  typedef struct {
    logic [2:0] idx;
    int         due;
  } sbEntry_t;

  logic clk;
  logic reset;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int cycle      = 0;

  sbEntry_t sbQ[$];

  branch_history_indexer_if #(.HIST_W(3)) bus ();

  branch_history_indexer #(
    .HIST_W(3),
    .PC_LSB(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, sample 1 ns later, and retire any scoreboard
  // entries whose index is due on PHTinpId at this edge.
  task automatic cyc();
    sbEntry_t e;
    @(posedge clk);
    #1;
    cycle++;
    while (sbQ.size() > 0 && sbQ[0].due == cycle) begin
      e = sbQ.pop_front();
      check("pipe_PHTinpId", {29'd0, bus.PHTinpId}, {29'd0, e.idx});
    end
  endtask

  task automatic idle();
    bus.stallD           = 1'b0;
    bus.flushD           = 1'b0;
    bus.flushE           = 1'b0;
    bus.branchD          = 1'b0;
    bus.predTakenD       = 1'b0;
    bus.branchE          = 1'b0;
    bus.branchTakenE     = 1'b0;
    bus.branchPredictedE = 1'b0;
  endtask

  task automatic setE(input logic b, input logic t, input logic p);
    bus.branchE          = b;
    bus.branchTakenE     = t;
    bus.branchPredictedE = p;
  endtask

  task automatic setD(input logic b, input logic pt);
    bus.branchD    = b;
    bus.predTakenD = pt;
  endtask

  initial begin
    logic [31:0] pcs [5];
    logic [2:0]  specExp [3];
    logic        predSeq [3];
    logic [31:0] pc;
    sbEntry_t    e;

    pcs[0] = 32'h04; pcs[1] = 32'h08; pcs[2] = 32'h0C; pcs[3] = 32'h00; pcs[4] = 32'h00;
    predSeq[0] = 1'b1; predSeq[1] = 1'b1; predSeq[2] = 1'b0;
    specExp[0] = 3'b001; specExp[1] = 3'b011; specExp[2] = 3'b110;

    // ---------------- reset ----------------
    idle();
    reset   = 1'b0;
    bus.PCF = 32'h1C;
    #1;
    check("rst_phtIdxF", {29'd0, bus.phtIdxF}, 32'h7);
    check("rst_PHTinpId", {29'd0, bus.PHTinpId}, 32'h0);
    check("rst_specHist", {29'd0, bus.specHist}, 32'h0);
    check("rst_commitHist", {29'd0, bus.commitHist}, 32'h0);
    check("rst_mispredictE", {31'd0, bus.mispredictE}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b1;
    bus.PCF = 32'h0;

    // ---------------- pipelining ----------------
    for (int k = 0; k < 5; k++) begin
      pc      = pcs[k];
      bus.PCF = pc;
      #1;
      check("pipe_phtIdxF", {29'd0, bus.phtIdxF}, {29'd0, pc[4:2]});
      if (k < 3) begin
        e.idx = pc[4:2];
        e.due = cycle + 2;
        sbQ.push_back(e);
      end
      cyc();
    end
    check("pipe_sb_drained", sbQ.size(), 0);

    // ---------------- speculative shift ----------------
    for (int k = 0; k < 3; k++) begin
      setD(1'b1, predSeq[k]);
      cyc();
      check("spec_shift", {29'd0, bus.specHist}, {29'd0, specExp[k]});
      check("spec_commit_hold", {29'd0, bus.commitHist}, 32'h0);
    end
    setD(1'b0, 1'b0);
    bus.PCF = 32'h1C;
    #1;
    check("spec_phtIdxF", {29'd0, bus.phtIdxF}, 32'h1);
    bus.PCF = 32'h0;

    // ---------------- commit / correct resolve ----------------
    setE(1'b1, 1'b1, 1'b1);
    cyc();
    check("commit_1", {29'd0, bus.commitHist}, 32'h1);
    setE(1'b1, 1'b0, 1'b0);
    cyc();
    check("commit_2", {29'd0, bus.commitHist}, 32'h2);
    check("commit_spec_hold", {29'd0, bus.specHist}, 32'h6);
    setE(1'b1, 1'b1, 1'b1);
    setD(1'b1, 1'b1);
    #1;
    check("resolve_no_mispredict", {31'd0, bus.mispredictE}, 32'h0);
    cyc();
    check("resolve_commit", {29'd0, bus.commitHist}, 32'h5);
    check("resolve_spec", {29'd0, bus.specHist}, 32'h5);

    // Set up commitHist=011, specHist=110.
    setE(1'b1, 1'b1, 1'b1);
    setD(1'b1, 1'b1);
    cyc();
    setE(1'b0, 1'b0, 1'b0);
    setD(1'b1, 1'b0);
    cyc();
    check("setup_commit", {29'd0, bus.commitHist}, 32'h3);
    check("setup_spec", {29'd0, bus.specHist}, 32'h6);

    // ---------------- mispredict recovery ----------------
    setE(1'b1, 1'b0, 1'b1);
    setD(1'b1, 1'b1);
    #1;
    check("mispredictE", {31'd0, bus.mispredictE}, 32'h1);
    cyc();
    check("recover_spec", {29'd0, bus.specHist}, 32'h6);
    check("recover_commit", {29'd0, bus.commitHist}, 32'h6);
    check("recover_phtIdxF", {29'd0, bus.phtIdxF}, 32'h6);

    // ---------------- flushE blocks speculative update ----------------
    setE(1'b0, 1'b0, 1'b0);
    bus.flushE = 1'b1;
    setD(1'b1, 1'b1);
    cyc();
    check("flushE_spec", {29'd0, bus.specHist}, 32'h6);
    check("flushE_PHTinpId", {29'd0, bus.PHTinpId}, 32'h0);
    bus.flushE = 1'b0;
    setD(1'b0, 1'b0);
    setE(1'b1, 1'b1, 1'b0);
    #1;
    check("flushE_bubble_nomis", {31'd0, bus.mispredictE}, 32'h0);
    cyc();
    check("flushE_bubble_nocommit", {29'd0, bus.commitHist}, 32'h6);
    setE(1'b0, 1'b0, 1'b0);

    // ---------------- stall / flushD ----------------
    bus.PCF = 32'h08;
    #1;
    check("stall_pre_phtIdxF", {29'd0, bus.phtIdxF}, 32'h4);
    cyc();
    bus.PCF     = 32'h0C;
    bus.stallD  = 1'b1;
    setD(1'b1, 1'b1);
    cyc();
    check("stall1_spec", {29'd0, bus.specHist}, 32'h6);
    check("stall1_PHTinpId", {29'd0, bus.PHTinpId}, 32'h0);
    setE(1'b1, 1'b1, 1'b0);
    #1;
    check("stall_bubble_nomis", {31'd0, bus.mispredictE}, 32'h0);
    cyc();
    check("stall2_spec", {29'd0, bus.specHist}, 32'h6);
    check("stall2_PHTinpId", {29'd0, bus.PHTinpId}, 32'h0);
    check("stall2_commit", {29'd0, bus.commitHist}, 32'h6);
    setE(1'b0, 1'b0, 1'b0);
    setD(1'b0, 1'b0);
    bus.stallD = 1'b0;
    cyc();
    check("stall_held_idxD", {29'd0, bus.PHTinpId}, 32'h4);
    bus.flushD = 1'b1;
    cyc();
    check("flushD_prev_idx", {29'd0, bus.PHTinpId}, 32'h5);
    bus.flushD = 1'b0;
    setD(1'b1, 1'b1);
    cyc();
    check("flushD_bubble_nospec", {29'd0, bus.specHist}, 32'h6);
    check("flushD_bubble_PHTinpId", {29'd0, bus.PHTinpId}, 32'h0);
    setD(1'b0, 1'b0);
    setE(1'b1, 1'b1, 1'b0);
    #1;
    check("flushD_bubble_nomis", {31'd0, bus.mispredictE}, 32'h0);
    setE(1'b0, 1'b0, 1'b0);

    // ---------------- asynchronous reset mid-run ----------------
    setD(1'b1, 1'b1);
    cyc();
    check("pre_reset_spec", {29'd0, bus.specHist}, 32'h5);
    setD(1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_spec", {29'd0, bus.specHist}, 32'h0);
    check("async_rst_commit", {29'd0, bus.commitHist}, 32'h0);
    check("async_rst_PHTinpId", {29'd0, bus.PHTinpId}, 32'h0);
    cyc();
    reset = 1'b1;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
